// File: rtl/imem_arb_pkg.sv
// Shared types for the instruction-memory port arbiter: the owner tag,
// the return-stage record and the default loader burst length.
package imem_arb_pkg;

    typedef enum logic {
        OWN_FETCH  = 1'b0,
        OWN_LOADER = 1'b1
    } owner_e;

    typedef struct packed {
        logic   valid;
        owner_e owner;
        logic   err;
    } ret_s;

    localparam int BURST_MAX_DEF = 4;

endpackage

// File: rtl/imem_port_arbiter_rr_arb2.sv
// Two-input round-robin arbiter (fetch vs loader) with a "last served" register.
// Optional feature macro IMEM_ARB_BURST_EN: lets the loader hold the port for up
// to BURST_MAX consecutive grants while fetch waits.
module rr_arb2
    import imem_arb_pkg::*;
#(
    parameter int BURST_MAX = BURST_MAX_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic req_f,
    input  logic req_l,
    output logic gnt_f,
    output logic gnt_l
);

    if (BURST_MAX < 1) begin : g_burst_max_invalid
        $error("rr_arb2: BURST_MAX must be at least 1");
    end

    owner_e last_q;
    owner_e last_d;
    logic   loader_wins;

`ifdef IMEM_ARB_BURST_EN
    localparam int CW = $clog2(BURST_MAX + 1);
    localparam logic [CW-1:0] BURST_TOP = CW'(BURST_MAX);

    logic [CW-1:0] burst_q;
    logic [CW-1:0] burst_d;

    // An open loader burst below its cap keeps the port; otherwise plain alternation.
    assign loader_wins = (last_q == OWN_FETCH) || ((burst_q != '0) && (burst_q < BURST_TOP));

    // Count consecutive loader grants; fetch grant or a dropped loader request closes the burst.
    always_comb begin
        burst_d = burst_q;
        if (gnt_f || !req_l) begin
            burst_d = '0;
        end else if (gnt_l && (burst_q < BURST_TOP)) begin
            burst_d = burst_q + 1'b1;
        end
    end

    // Burst counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            burst_q <= '0;
        end else begin
            burst_q <= burst_d;
        end
    end
`else
    assign loader_wins = (last_q == OWN_FETCH);
`endif

    // Grant decision; everything is held off while reset is asserted.
    always_comb begin
        gnt_f = 1'b0;
        gnt_l = 1'b0;
        if (reset) begin
            if (req_f && req_l) begin
                gnt_l = loader_wins;
                gnt_f = !loader_wins;
            end else begin
                gnt_f = req_f;
                gnt_l = req_l;
            end
        end
    end

    // Remember who was served last; idle cycles keep the previous owner.
    always_comb begin
        last_d = last_q;
        if (gnt_f) begin
            last_d = OWN_FETCH;
        end else if (gnt_l) begin
            last_d = OWN_LOADER;
        end
    end

    // Last-owner register; reset to loader so fetch wins the first contention.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_q <= OWN_LOADER;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/imem_port_arbiter.sv
// Instruction-memory port arbiter between the fetch path and the program loader.
// Muxes the winner onto the memory port, tags one-cycle read returns to their
// owner and raises the fetch stall. Optional feature macro: IMEM_ARB_BURST_EN.
module imem_port_arbiter
    import imem_arb_pkg::*;
#(
    parameter int N         = 32,
    parameter int BURST_MAX = BURST_MAX_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         f_req,
    input  logic [N-1:0] f_addr,
    output logic         f_gnt,
    output logic         f_rvalid,
    output logic [N-1:0] f_rdata,
    output logic         f_err,
    input  logic         l_req,
    input  logic         l_we,
    input  logic [N-1:0] l_addr,
    input  logic [N-1:0] l_wdata,
    output logic         l_gnt,
    output logic         l_rvalid,
    output logic [N-1:0] l_rdata,
    output logic         l_err,
    output logic         mem_en,
    output logic         mem_we,
    output logic [N-1:0] mem_addr,
    output logic [N-1:0] mem_wdata,
    input  logic [N-1:0] mem_rdata,
    output logic         stall
);

    ret_s ret_q;
    ret_s ret_d;
    logic misaligned;

    rr_arb2 #(
        .BURST_MAX(BURST_MAX)
    ) u_arb (
        .clk  (clk),
        .reset(reset),
        .req_f(f_req),
        .req_l(l_req),
        .gnt_f(f_gnt),
        .gnt_l(l_gnt)
    );

    // Drive the memory port from the winner; misaligned accesses never enable memory.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        if (f_gnt) begin
            mem_addr = f_addr;
        end else if (l_gnt) begin
            mem_addr  = l_addr;
            mem_wdata = l_wdata;
            mem_we    = l_we;
        end
        misaligned = (mem_addr[1:0] != 2'b00);
        mem_en     = (f_gnt || l_gnt) && !misaligned;
    end

    assign stall = f_req && !f_gnt;

    // Build the return record: every grant returns except an aligned loader write.
    always_comb begin
        ret_d.valid = f_gnt || (l_gnt && (!l_we || misaligned));
        ret_d.owner = l_gnt ? OWN_LOADER : OWN_FETCH;
        ret_d.err   = misaligned;
    end

    // Return pipeline register; reset drops any read still in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ret_q <= '{valid: 1'b0, owner: OWN_FETCH, err: 1'b0};
        end else begin
            ret_q <= ret_d;
        end
    end

    // Steer the returned word to its owner; errored returns carry zero data.
    always_comb begin
        f_rvalid = ret_q.valid && (ret_q.owner == OWN_FETCH);
        l_rvalid = ret_q.valid && (ret_q.owner == OWN_LOADER);
        f_err    = f_rvalid && ret_q.err;
        l_err    = l_rvalid && ret_q.err;
        f_rdata  = (f_rvalid && !ret_q.err) ? mem_rdata : '0;
        l_rdata  = (l_rvalid && !ret_q.err) ? mem_rdata : '0;
    end

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed bench for imem_port_arbiter with a behavioural memory and a
// scoreboard queue of expected read returns.
module tb_imem_port_arbiter;
    import imem_arb_pkg::*;

    localparam int N = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         f_req;
    logic [N-1:0] f_addr;
    logic         f_gnt;
    logic         f_rvalid;
    logic [N-1:0] f_rdata;
    logic         f_err;
    logic         l_req;
    logic         l_we;
    logic [N-1:0] l_addr;
    logic [N-1:0] l_wdata;
    logic         l_gnt;
    logic         l_rvalid;
    logic [N-1:0] l_rdata;
    logic         l_err;
    logic         mem_en;
    logic         mem_we;
    logic [N-1:0] mem_addr;
    logic [N-1:0] mem_wdata;
    logic [N-1:0] mem_rdata;
    logic         stall;

    int total = 0;
    int bad   = 0;

    typedef struct {
        owner_e      owner;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t sbq[$];

    logic [N-1:0] mem     [64];
    logic [N-1:0] ref_mem [64];

    imem_port_arbiter #(
        .N        (N),
        .BURST_MAX(4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .f_req    (f_req),
        .f_addr   (f_addr),
        .f_gnt    (f_gnt),
        .f_rvalid (f_rvalid),
        .f_rdata  (f_rdata),
        .f_err    (f_err),
        .l_req    (l_req),
        .l_we     (l_we),
        .l_addr   (l_addr),
        .l_wdata  (l_wdata),
        .l_gnt    (l_gnt),
        .l_rvalid (l_rvalid),
        .l_rdata  (l_rdata),
        .l_err    (l_err),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .stall    (stall)
    );

    always #5 clk = ~clk;

    // Behavioural instruction memory: one-cycle read latency, write on enable.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                mem[mem_addr[7:2]] = mem_wdata;
            end else begin
                mem_rdata <= mem[mem_addr[7:2]];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // One clock: check returns and grants at the falling edge, then let the rising edge happen.
    task automatic step(input logic ef, input logic el, input logic em);
        exp_t e;
        @(negedge clk);
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            if (e.owner == OWN_FETCH) begin
                chk("f_rvalid", {31'd0, f_rvalid}, 32'd1);
                chk("f_rdata", f_rdata, e.data);
                chk("f_err", {31'd0, f_err}, {31'd0, e.err});
                chk("l_rvalid_idle", {31'd0, l_rvalid}, 32'd0);
            end else begin
                chk("l_rvalid", {31'd0, l_rvalid}, 32'd1);
                chk("l_rdata", l_rdata, e.data);
                chk("l_err", {31'd0, l_err}, {31'd0, e.err});
                chk("f_rvalid_idle", {31'd0, f_rvalid}, 32'd0);
            end
        end else begin
            chk("f_rvalid_none", {31'd0, f_rvalid}, 32'd0);
            chk("l_rvalid_none", {31'd0, l_rvalid}, 32'd0);
            chk("f_rdata_none", f_rdata, 32'd0);
            chk("l_rdata_none", l_rdata, 32'd0);
            chk("f_err_none", {31'd0, f_err}, 32'd0);
            chk("l_err_none", {31'd0, l_err}, 32'd0);
        end
        chk("f_gnt", {31'd0, f_gnt}, {31'd0, ef});
        chk("l_gnt", {31'd0, l_gnt}, {31'd0, el});
        chk("stall", {31'd0, stall}, {31'd0, f_req & ~ef});
        chk("mem_en", {31'd0, mem_en}, {31'd0, em});
        if (ef) begin
            chk("mem_addr_f", mem_addr, f_addr);
            chk("mem_we_f", {31'd0, mem_we}, 32'd0);
            e.owner = OWN_FETCH;
            e.err   = (f_addr[1:0] != 2'b00);
            e.data  = e.err ? 32'd0 : ref_mem[f_addr[7:2]];
            sbq.push_back(e);
        end else if (el) begin
            chk("mem_addr_l", mem_addr, l_addr);
            chk("mem_we_l", {31'd0, mem_we}, {31'd0, l_we});
            if (l_we) chk("mem_wdata_l", mem_wdata, l_wdata);
            e.owner = OWN_LOADER;
            e.err   = (l_addr[1:0] != 2'b00);
            e.data  = (e.err || l_we) ? 32'd0 : ref_mem[l_addr[7:2]];
            if (!l_we || e.err) sbq.push_back(e);
            if (l_we && !e.err) ref_mem[l_addr[7:2]] = l_wdata;
        end else begin
            chk("mem_addr_idle", mem_addr, 32'd0);
            chk("mem_wdata_idle", mem_wdata, 32'd0);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic ef;
        for (int i = 0; i < 64; i++) begin
            mem[i]     = 32'hC0DE_0000 ^ (i * 32'h0101_0004);
            ref_mem[i] = 32'hC0DE_0000 ^ (i * 32'h0101_0004);
        end
        mem_rdata = '0;
        reset   = 1'b0;
        f_req   = 1'b1;
        f_addr  = 32'h0;
        l_req   = 1'b1;
        l_we    = 1'b0;
        l_addr  = 32'h0;
        l_wdata = 32'h0;

        // Reset holds grants and memory enable off even with both requesting.
        @(posedge clk);
        #1;
        step(1'b0, 1'b0, 1'b0);
        f_req = 1'b0;
        l_req = 1'b0;
        step(1'b0, 1'b0, 1'b0);
        reset = 1'b1;

        // Fetch only: consecutive words, no stall, returns one cycle later.
        f_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            f_addr = 32'(i * 4);
            step(1'b1, 1'b0, 1'b1);
        end
        f_req = 1'b0;
        step(1'b0, 1'b0, 1'b0);

        // Loader write then fetch of the same word.
        l_req   = 1'b1;
        l_we    = 1'b1;
        l_addr  = 32'h10;
        l_wdata = 32'hDEAD_BEEF;
        step(1'b0, 1'b1, 1'b1);
        l_req  = 1'b0;
        l_we   = 1'b0;
        f_req  = 1'b1;
        f_addr = 32'h10;
        step(1'b1, 1'b0, 1'b1);
        f_req = 1'b0;
        step(1'b0, 1'b0, 1'b0);
        chk("ref_word_0x10", ref_mem[4], 32'hDEAD_BEEF);

        // Misaligned fetch and misaligned loader write both return an error.
        f_req  = 1'b1;
        f_addr = 32'h6;
        step(1'b1, 1'b0, 1'b0);
        f_req   = 1'b0;
        l_req   = 1'b1;
        l_we    = 1'b1;
        l_addr  = 32'h13;
        l_wdata = 32'h1234_5678;
        step(1'b0, 1'b1, 1'b0);
        l_req = 1'b0;
        l_we  = 1'b0;
        step(1'b0, 1'b0, 1'b0);

        // Contention from a fresh reset: fetch wins first.
        reset = 1'b0;
        step(1'b0, 1'b0, 1'b0);
        reset  = 1'b1;
        f_req  = 1'b1;
        f_addr = 32'h24;
        l_req  = 1'b1;
        l_addr = 32'h20;
        for (int i = 0; i < 10; i++) begin
`ifdef IMEM_ARB_BURST_EN
            ef = (i % 5 == 0);
`else
            ef = (i % 2 == 0);
`endif
            step(ef, !ef, 1'b1);
        end
        f_req = 1'b0;
        l_req = 1'b0;
        step(1'b0, 1'b0, 1'b0);

        // Loader read alone returns on the loader side.
        l_req  = 1'b1;
        l_addr = 32'h30;
        step(1'b0, 1'b1, 1'b1);
        l_req = 1'b0;
        step(1'b0, 1'b0, 1'b0);

        // Reset the cycle after a fetch grant: the read is discarded.
        f_req  = 1'b1;
        f_addr = 32'h8;
        step(1'b1, 1'b0, 1'b1);
        reset = 1'b0;
        f_req = 1'b0;
        sbq.delete();
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        f_req  = 1'b1;
        f_addr = 32'h4;
        l_req  = 1'b1;
        l_addr = 32'h8;
        step(1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        f_req = 1'b0;
        l_req = 1'b0;
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
